// File: rtl/instruction_loader.sv
// Streams program bytes into instruction memory: four bytes are packed big-endian
// into one word, then written to consecutive word addresses starting at base_addr.
module instruction_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   base_addr,
  input  logic [CW-1:0] word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] words_written
);

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned IW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]   base_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   byte_idx;
  logic [3*BW-1:0] asm_q;

  logic            accept_c;
  logic            xfer_c;
  logic            range_err_c;
  logic            last_word_c;
  logic [AW:0]     end_addr_c;

  logic            ready_d;
  logic            we_d;
  logic            busy_d;
  logic            done_d;

  // Range check is done one bit wider than the address so base+count cannot wrap.
  assign end_addr_c  = {1'b0, base_addr} + (AW+1)'(word_count);
  assign range_err_c = end_addr_c > (AW+1)'(DEPTH);
  assign accept_c    = (state == IDLE) && start;
  assign xfer_c      = (state == LOAD) && byte_valid;
  assign last_word_c = (words_written + CW'(1)) == count_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if ((word_count == '0) || range_err_c) state_next = DONE;
          else                                   state_next = LOAD;
        end
      end
      LOAD: begin
        if (xfer_c && (byte_idx == IW'(3))) state_next = WRITE;
      end
      WRITE: begin
        if (last_word_c) state_next = DONE;
        else             state_next = LOAD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state, so the flops below track the state register.
  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_next)
      LOAD: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      WRITE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      byte_ready <= ready_d;
      mem_we     <= we_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Request capture, byte assembly and word-write datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q        <= '0;
      count_q       <= '0;
      byte_idx      <= '0;
      asm_q         <= '0;
      error         <= 1'b0;
      words_written <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      if (accept_c) begin
        base_q        <= base_addr;
        count_q       <= word_count;
        error         <= range_err_c;
        words_written <= '0;
        byte_idx      <= '0;
      end
      if (xfer_c) begin
        asm_q    <= {asm_q[2*BW-1:0], byte_in};
        byte_idx <= byte_idx + IW'(1);
        if (byte_idx == IW'(3)) begin
          mem_addr  <= base_q + AW'(words_written);
          mem_wdata <= {asm_q, byte_in};
        end
      end
      if (state == WRITE) words_written <= words_written + CW'(1);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: expected memory writes are queued as
// stimulus is driven and popped by a write monitor as mem_we strobes appear.
module tb_instruction_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = 9;
  localparam int          TMO   = 200;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_written;

  instruction_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int we_cyc = -1;
  int xfer_cyc = -1;
  int done_cyc = -1;
  logic [31:0] last_addr = '0;
  logic        prev_we   = 1'b0;
  logic [63:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (mem_we) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_addr, mem_wdata);
        end else begin
          logic [63:0] exp;
          exp = sb.pop_front();
          if ({mem_addr, mem_wdata} !== exp) begin
            n_fail++;
            $display("FAIL write_payload: addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_wdata, exp[63:32], exp[31:0]);
          end
        end
        n_chk++;
        if (byte_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_in_write: byte_ready=%b, expected 0", byte_ready);
        end
        n_chk++;
        if (prev_we !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL we_shape: prev_we=%b busy=%b, expected 0/1", prev_we, busy);
        end
        wr_cnt++;
        we_cyc    = cyc;
        last_addr = mem_addr;
      end
      prev_we = mem_we;
    end
  end

  function automatic logic [31:0] fr_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  task automatic do_start(input logic [31:0] b, input logic [CW-1:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_in = b; byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_chk++; n_fail++;
      $display("FAIL byte_timeout: byte_ready=%b after %0d cycles, expected 1", byte_ready, n);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    xfer_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[31-8*k -: 8];
      send_byte(b, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 4000) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b, expected a pulse", done);
    end
    done_cyc = cyc;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b busy=%b one cycle later, expected 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({byte_ready, mem_we, busy, done, error} !== 5'b0 || words_written !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b we=%b busy=%b done=%b err=%b ww=%0d addr=%h data=%h, expected all 0",
               byte_ready, mem_we, busy, done, error, words_written, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int w0;
    w0 = wr_cnt;
    do_start(32'd0, CW'(1));
    n_chk++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: busy=%b byte_ready=%b, expected 1/1", busy, byte_ready);
    end
    sb.push_back({32'd0, 32'h02B4B020});
    send_word(32'h02B4B020, 0);
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 1 || words_written !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_count: writes=%0d ww=%0d, expected 1/1", wr_cnt - w0, words_written);
    end
    n_chk++;
    if (we_cyc != xfer_cyc || done_cyc != we_cyc + 1) begin
      n_fail++;
      $display("FAIL single_timing: xfer=%0d we=%0d done=%0d, expected we=xfer and done=we+1",
               xfer_cyc, we_cyc, done_cyc);
    end
  endtask

  task automatic test_gapped_stream();
    int w0;
    logic [31:0] w;
    w0 = wr_cnt;
    do_start(32'd14, CW'(3));
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      sb.push_back({32'd14 + 32'(i), w});
      send_word(w, 3);
    end
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 3 || words_written !== CW'(3) || last_addr !== 32'd16 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL gapped_count: writes=%0d ww=%0d last=%0d pend=%0d, expected 3/3/16/0",
               wr_cnt - w0, words_written, last_addr, sb.size());
    end
  endtask

  task automatic test_zero_and_range();
    int w0;
    w0 = wr_cnt;
    do_start(32'd5, CW'(0));
    wait_done();
    n_chk++;
    if (wr_cnt != w0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: writes=%0d err=%b, expected 0/0", wr_cnt - w0, error);
    end
    do_start(32'd250, CW'(10));
    wait_done();
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_cnt != w0 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL range_error: writes=%0d err=%b, expected 0/1", wr_cnt - w0, error);
    end
    do_start(32'd246, CW'(1));
    n_chk++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: err=%b, expected 0", error);
    end
    sb.push_back({32'd246, 32'hCAFE0011});
    send_word(32'hCAFE0011, 1);
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 1 || last_addr !== 32'd246) begin
      n_fail++;
      $display("FAIL after_error_load: writes=%0d last=%0d, expected 1/246", wr_cnt - w0, last_addr);
    end
  endtask

  task automatic test_start_in_load();
    int w0;
    w0 = wr_cnt;
    do_start(32'd40, CW'(2));
    sb.push_back({32'd40, 32'h11223344});
    sb.push_back({32'd41, 32'h55667788});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(32'd99, CW'(7));
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    send_word(32'h55667788, 2);
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 2 || words_written !== CW'(2) || last_addr !== 32'd41) begin
      n_fail++;
      $display("FAIL start_ignored: writes=%0d ww=%0d last=%0d, expected 2/2/41",
               wr_cnt - w0, words_written, last_addr);
    end
  endtask

  task automatic test_reset_mid_load();
    int w0;
    do_start(32'd3, CW'(2));
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({byte_ready, mem_we, busy, done, error} !== 5'b0 || words_written !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b we=%b busy=%b done=%b err=%b ww=%0d addr=%h data=%h, expected all 0",
               byte_ready, mem_we, busy, done, error, words_written, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt;
    do_start(32'd26, CW'(1));
    sb.push_back({32'd26, 32'h08000074});
    send_word(32'h08000074, 0);
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 1 || mem_wdata !== 32'h08000074 || mem_addr !== 32'd26) begin
      n_fail++;
      $display("FAIL post_reset_load: writes=%0d addr=%0d data=%h, expected 1/26/08000074",
               wr_cnt - w0, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_full_range();
    int w0;
    w0 = wr_cnt;
    do_start(32'd0, CW'(256));
    for (int i = 0; i < 256; i++) begin
      sb.push_back({32'(i), fr_word(i)});
      send_word(fr_word(i), 0);
    end
    wait_done();
    n_chk++;
    if (wr_cnt - w0 != 256 || words_written !== CW'(256) || last_addr !== 32'd255 ||
        error !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_range: writes=%0d ww=%0d last=%0d err=%b pend=%0d, expected 256/256/255/0/0",
               wr_cnt - w0, words_written, last_addr, error, sb.size());
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (mem_addr !== 32'd255 || mem_wdata !== fr_word(255)) begin
      n_fail++;
      $display("FAIL idle_hold: addr=%0d data=%h, expected 255/%h", mem_addr, mem_wdata, fr_word(255));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gapped_stream();
    test_zero_and_range();
    test_start_in_load();
    test_reset_mid_load();
    test_full_range();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
